// File: rtl/shift_seq_pkg.sv
// ============================================================================
// Module   : shift_seq_pkg
// Brief    : Shared mode, state and datapath-command encodings for shift_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_seq_pkg;

    typedef enum logic [1:0] {
        MODE_SHR = 2'd0,
        MODE_SHL = 2'd1,
        MODE_ROR = 2'd2,
        MODE_ROL = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'd0,
        CMD_LOAD = 2'd1,
        CMD_STEP = 2'd2
    } cmd_t;

endpackage

`default_nettype wire

// File: rtl/shift_seq_ctrl_core.sv
// ============================================================================
// Module   : shift_core
// Brief    : Shift/rotate datapath holding q and sout; obeys hold/load/step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_core
    import shift_seq_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  cmd_t         cmd,
    input  mode_t        mode,
    input  logic         sin,
    input  logic [N-1:0] load_data,
    output logic [N-1:0] q,
    output logic         sout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            sout <= 1'b0;
        end else begin
            case (cmd)
                CMD_LOAD: q <= load_data;
                CMD_STEP: begin
                    case (mode)
                        MODE_SHR: begin
                            q    <= {sin, q[N-1:1]};
                            sout <= q[0];
                        end
                        MODE_SHL: begin
                            q    <= {q[N-2:0], sin};
                            sout <= q[N-1];
                        end
                        MODE_ROR: begin
                            q    <= {q[0], q[N-1:1]};
                            sout <= q[0];
                        end
                        default: begin
                            q    <= {q[N-2:0], q[N-1]};
                            sout <= q[N-1];
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
// ============================================================================
// Module   : shift_seq_ctrl
// Brief    : Job-sequencing FSM and step counter driving the shift_core datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int N  = 5,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_mode,
    input  logic [CW-1:0] req_count,
    input  logic [N-1:0]  req_data,
    input  logic          abort,
    input  logic          sin,
    output logic [N-1:0]  q,
    output logic          sout,
    output logic          busy,
    output logic          done
);

    state_t        r_state;
    mode_t         r_mode;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_data;
    logic          r_ready;
    logic          r_busy;
    logic          r_done;
    cmd_t          w_cmd;

    // Abort suppresses both the load and the step on the edge it is sampled.
    always_comb begin
        w_cmd = CMD_HOLD;
        if (!abort) begin
            if (r_state == ST_LOAD) begin
                w_cmd = CMD_LOAD;
            end else if (r_state == ST_SHIFT) begin
                w_cmd = CMD_STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_SHR;
            r_count <= '0;
            r_data  <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_mode  <= mode_t'(req_mode);
                        r_count <= req_count;
                        r_data  <= req_data;
                        r_state <= ST_LOAD;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_count == '0) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        // Counter is never zero here, so the decrement cannot wrap.
                        r_count <= r_count - 1'b1;
                        if (r_count == CW'(1)) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;

    shift_core #(
        .N (N)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .cmd       (w_cmd),
        .mode      (r_mode),
        .sin       (sin),
        .load_data (r_data),
        .q         (q),
        .sout      (sout)
    );

endmodule

`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
// ============================================================================
// Module   : tb_shift_seq_ctrl
// Brief    : Randomized scoreboard bench for shift_seq_ctrl against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_seq_ctrl;

    localparam int N    = 5;
    localparam int CW   = 4;
    localparam int MASK = (1 << N) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_mode;
    logic [CW-1:0] req_count;
    logic [N-1:0]  req_data;
    logic          abort;
    logic          sin;
    logic [N-1:0]  q;
    logic          sout;
    logic          busy;
    logic          done;

    typedef struct {
        int q;
        int sout;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   mq    = 0;
    int   ms    = 0;

    shift_seq_ctrl #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .req_count (req_count),
        .req_data  (req_data),
        .abort     (abort),
        .sin       (sin),
        .q         (q),
        .sout      (sout),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One operation step expressed as integer arithmetic on the register value.
    task automatic model_step(input int mode, input int s, inout int qv, inout int so);
        case (mode)
            0: begin so = qv & 1;            qv = (qv >> 1) | (s << (N - 1)); end
            1: begin so = (qv >> (N-1)) & 1; qv = ((qv << 1) & MASK) | s;     end
            2: begin so = qv & 1;            qv = (qv >> 1) | (so << (N - 1)); end
            default: begin so = (qv >> (N-1)) & 1; qv = ((qv << 1) & MASK) | so; end
        endcase
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("done_q", int'(q), e.q);
                check("done_sout", int'(sout), e.sout);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge with the DUT idle. abort_at = m asserts abort so that it is
    // sampled on edge T+m+1; rst_at = m pulses reset after edge T+m (SHIFT only).
    task automatic run_job(input int mode, input int count, input int data,
                           input logic [31:0] bits, input int abort_at, input int rst_at);
        int lq, ls;
        check("ready_before_job", int'(req_ready), 1);
        req_valid = 1'b1;
        req_mode  = 2'(mode);
        req_count = CW'(count);
        req_data  = N'(data);
        abort     = 1'b0;
        if (abort_at < 0 && rst_at < 0) begin
            lq = data;
            ls = ms;
            for (int k = 1; k <= count; k++) model_step(mode, int'(bits[k]), lq, ls);
            sb.push_back('{q: lq, sout: ls, cyc: cyc + 2 + count});
        end
        for (int m = 0; m <= count + 2; m++) begin
            @(posedge clk);
            @(negedge clk);
            if (m > 0 && abort_at == m - 1) begin
                check("abort_q_held", int'(q), mq);
                check("abort_sout_held", int'(sout), ms);
                check("abort_busy", int'(busy), 0);
                check("abort_ready", int'(req_ready), 1);
                abort     = 1'b0;
                req_valid = 1'b0;
                return;
            end
            if (m == 1) mq = data;
            else if (m >= 2 && m <= count + 1) model_step(mode, int'(bits[m-1]), mq, ms);
            if (m >= 1) begin
                check("q_track", int'(q), mq);
                check("sout_track", int'(sout), ms);
            end
            if (m <= count) begin
                check("busy_in_job", int'(busy), 1);
                check("ready_in_job", int'(req_ready), 0);
            end else if (m == count + 2) begin
                check("ready_after_done", int'(req_ready), 1);
                check("done_one_cycle", int'(done), 0);
                return;
            end
            if (rst_at == m) begin
                req_valid = 1'b0;
                #2 rst = 1'b1;
                #1;
                mq = 0;
                ms = 0;
                check("rst_q", int'(q), 0);
                check("rst_sout", int'(sout), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_ready", int'(req_ready), 1);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            // Requests while busy must be ignored.
            req_valid = (m < count) ? 1'($urandom) : 1'b0;
            req_mode  = 2'($urandom);
            req_count = CW'($urandom);
            req_data  = N'($urandom);
            sin       = bits[m];
            abort     = (abort_at == m);
        end
    endtask

    initial begin
        int mode, count, ab, rs;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_mode  = '0;
        req_count = '0;
        req_data  = '0;
        abort     = 1'b0;
        sin       = 1'b0;
        #1;
        check("reset_q", int'(q), 0);
        check("reset_sout", int'(sout), 0);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(req_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_job(0, 2, 5'b10110, 32'hFFFF_FFFF, -1, -1);
        run_job(3, 3, 5'b10011, 32'h0, -1, -1);
        run_job(2, 0, 5'b01010, 32'h0, -1, -1);
        run_job(1, 4, 5'b00001, 32'h0, 3, -1);
        run_job(1, 15, 5'b11001, 32'h0000_A5A5, -1, -1);
        run_job(2, 6, 5'b10101, 32'h0, -1, 3);
        run_job(0, 4, 5'b11111, 32'h0, 0, -1);
        run_job(3, 2, 5'b10000, 32'h0, 2, -1);

        for (int j = 0; j < 60; j++) begin
            mode  = int'($urandom_range(0, 3));
            count = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 15));
            ab    = -1;
            rs    = -1;
            if ($urandom_range(0, 4) == 0) ab = int'($urandom_range(0, count));
            else if (count >= 2 && $urandom_range(0, 9) == 0) rs = int'($urandom_range(1, count));
            run_job(mode, count, int'($urandom_range(0, MASK)), $urandom, ab, rs);
            repeat ($urandom_range(0, 2)) begin
                abort = 1'($urandom);
                @(negedge clk);
                check("idle_q_hold", int'(q), mq);
                check("idle_sout_hold", int'(sout), ms);
            end
            abort = 1'b0;
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
